branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised, registered branch/jump resolution for the execute stage.
//  - Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR and compares the outcome with the fetch-stage prediction.
//  - Raises a one-cycle flush with the corrected PC on a misprediction.
//  - Owns the branch history table (BHT) of saturating counters; fetch reads it, execute trains it.
//  - Keeps branch and mispredict performance counters.
// PARAMETERS
//  XLEN       32  data/PC width
//  BHT_DEPTH  64  number of BHT entries; must be a power of 2
//  CTR_BITS   2   width of each saturating counter
//  CNT_W      32  width of the performance counters
// PORTS
//  i_clk           in   1         clock; all state updates on the rising edge
//  i_rst_n         in   1         asynchronous, active-low reset
//  i_valid         in   1         execute-stage instruction valid
//  i_stall         in   1         pipeline stall; freezes all state
//  i_opcode        in   7         instruction opcode
//  i_func3         in   3         branch condition code
//  i_rs1_data      in   XLEN      rs1 operand (forwarded)
//  i_rs2_data      in   XLEN      rs2 operand (forwarded)
//  i_pc            in   XLEN      PC of the execute-stage instruction
//  i_imm           in   XLEN      sign-extended B/J/I immediate
//  i_pred_taken    in   1         fetch-stage prediction carried down the pipe
//  i_pred_pc       in   XLEN      predicted target carried down the pipe
//  i_fetch_pc      in   XLEN      fetch PC used for the BHT lookup
//  o_fetch_pred    out  1         BHT prediction for i_fetch_pc (combinational)
//  o_flush         out  1         registered mispredict flush
//  o_redirect_pc   out  XLEN      registered corrected PC
//  o_misalign      out  1         registered taken-target misaligned exception
//  o_illegal       out  1         registered illegal branch func3
//  o_branch_cnt    out  CNT_W     number of resolved branches and jumps
//  o_mispred_cnt   out  CNT_W     number of mispredictions
// BEHAVIOUR
//  Reset
//  - All outputs and both counters go to 0.
//  - Every BHT entry goes to weakly-not-taken, i.e. 2^(CTR_BITS-1)-1 (01 for 2 bits).
//  Decode
//  - BRANCH = 1100011, JAL = 1101111, JALR = 1100111; any other opcode is a no-op.
//  Conditions
//  - func3 000 BEQ (=), 001 BNE (!=), 100 BLT (signed <), 101 BGE (signed >=), 110 BLTU (unsigned <), 111 BGEU (unsigned >=).
//  - func3 010/011 on BRANCH: treated as not taken, o_illegal=1 next cycle, no BHT update.
//  Targets
//  - BRANCH and JAL: target = i_pc + i_imm.
//  - JALR: target = (i_rs1_data + i_imm) & ~1.
//  - All sums are XLEN bits and wrap modulo 2^XLEN.
//  - JAL and JALR are always taken.
//  Mispredict
//  - mispred = (taken != i_pred_taken) | (taken & (i_pred_pc != target)).
//  - redirect = taken ? target : i_pc + 4.
//  - A taken target with target[1] = 1 sets o_misalign=1 and forces o_flush=0; the trap unit owns the redirect.
//  Timing
//  - Latency is 1 cycle: outputs register at the edge after a qualifying i_valid.
//  - o_flush, o_misalign and o_illegal are single-cycle pulses.
//  - o_redirect_pc holds its last value when o_flush=0.
//  Squash
//  - While o_flush=1, the i_valid of that cycle is ignored (wrong path).
//  - A squashed instruction updates nothing: no BHT, no counters, no outputs.
//  Stall
//  - i_stall=1 freezes the BHT, counters and output registers.
//  - Stall takes priority over i_valid.
//  BHT
//  - Index = pc[log2(BHT_DEPTH)+1:2].
//  - o_fetch_pred = MSB of the entry indexed by i_fetch_pc.
//  - Only valid conditional branches with a legal func3 train: +1 if taken, -1 if not, saturating at all-ones and 0.
//  - A same-cycle lookup and update of one index returns the pre-update value.
//  Counters
//  - o_branch_cnt += 1 per valid, unsquashed BRANCH/JAL/JALR.
//  - o_mispred_cnt += 1 per o_flush pulse.
//  - Both wrap at 2^CNT_W.
//  Reset mid-operation
//  - Asserting i_rst_n=0 while a flush is pending clears it asynchronously; no stale redirect is issued after release.
// TESTING
//  - Reset -> all outputs 0; a lookup of any fetch PC gives o_fetch_pred=0.
//  - BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle o_flush=1, o_redirect_pc=0x120, mispred_cnt=1.
//  - BLTU rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> not taken; BLT on the same operands -> taken; check the flush/redirect of each.
//  - JALR rs1=0x203, imm=0 -> target 0x202, o_misalign=1, o_flush=0.
//  - Three taken branches at pc=0x40 -> the entry saturates at 3 (o_fetch_pred=1 from the 1st); three not-taken -> back to 0.
//  - Flush cycle with i_valid=1, then i_stall=1 for 2 cycles -> the squashed instruction changes nothing and state holds through the stall.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: condition evaluation, mispredict flush,
// BHT of saturating counters (read by fetch, trained here) and perf counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_func3,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_pc,
  input  logic [XLEN-1:0]  i_fetch_pc,
  output logic             o_fetch_pred,
  output logic             o_flush,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_misalign,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};

  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];

  logic             flush_q, misalign_q, illegal_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic             flush_d, misalign_d, illegal_d;
  logic [XLEN-1:0]  redirect_d;
  logic             is_br, is_jal, is_jalr, legal, cond, taken, mispred, qualify, train;
  logic [XLEN-1:0]  target;
  logic [IDX_W-1:0] upd_idx, fetch_idx;

  assign fetch_idx    = i_fetch_pc[IDX_W+1:2];
  assign upd_idx      = i_pc[IDX_W+1:2];
  assign o_fetch_pred = bht_q[fetch_idx][CTR_BITS-1];

  logic unused_ok;
  assign unused_ok = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0]};

  // Decode, condition evaluation and next-state of the output pulses.
  always_comb begin
    is_br   = (i_opcode == OP_BRANCH);
    is_jal  = (i_opcode == OP_JAL);
    is_jalr = (i_opcode == OP_JALR);
    legal   = (i_func3 != 3'b010) && (i_func3 != 3'b011);
    case (i_func3)
      3'b000:  cond = (i_rs1_data == i_rs2_data);
      3'b001:  cond = (i_rs1_data != i_rs2_data);
      3'b100:  cond = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      3'b101:  cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      3'b110:  cond = (i_rs1_data <  i_rs2_data);
      3'b111:  cond = (i_rs1_data >= i_rs2_data);
      default: cond = 1'b0;
    endcase
    if (is_jalr) begin
      target = (i_rs1_data + i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      target = i_pc + i_imm;
    end
    taken   = is_jal | is_jalr | (is_br & legal & cond);
    mispred = (taken != i_pred_taken) | (taken & (i_pred_pc != target));
    // The flush cycle's instruction is wrong-path and must not touch any state.
    qualify = i_valid & ~flush_q & (is_br | is_jal | is_jalr);
    train   = qualify & is_br & legal;

    misalign_d = qualify & taken & target[1];
    illegal_d  = qualify & is_br & ~legal;
    flush_d    = qualify & mispred & ~(taken & target[1]);
    redirect_d = taken ? target : (i_pc + {{(XLEN-3){1'b0}}, 3'd4});
  end

  // Output pulses, redirect PC and performance counters; stall freezes them all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_q    <= {XLEN{1'b0}};
      branch_cnt_q  <= {CNT_W{1'b0}};
      mispred_cnt_q <= {CNT_W{1'b0}};
    end else if (!i_stall) begin
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      if (flush_d) begin
        redirect_q <= redirect_d;
      end
      branch_cnt_q  <= branch_cnt_q + CNT_W'(qualify);
      mispred_cnt_q <= mispred_cnt_q + CNT_W'(flush_d);
    end
  end

  // BHT training: saturating increment on taken, decrement on not taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (!i_stall && train) begin
      if (taken) begin
        if (bht_q[upd_idx] != CTR_MAX) begin
          bht_q[upd_idx] <= bht_q[upd_idx] + CTR_BITS'(1);
        end
      end else begin
        if (bht_q[upd_idx] != CTR_MIN) begin
          bht_q[upd_idx] <= bht_q[upd_idx] - CTR_BITS'(1);
        end
      end
    end
  end

  assign o_flush       = flush_q;
  assign o_misalign    = misalign_q;
  assign o_illegal     = illegal_q;
  assign o_redirect_pc = redirect_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule
